// File: rtl/gigerx_pkg.sv
// Shared definitions for the gigabit RX byte-count path: word layout,
// FSM encoding and a helper that packs a length/status word.
package gigerx_pkg;

    localparam int LENW   = 14;
    localparam int BCW    = 16;
    localparam int BC_ERR = 15;
    localparam int BC_OVS = 14;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] IN_FRAME = 1'b1;

    function automatic logic [BCW-1:0] bc_pack(input logic err, input logic ovs,
                                               input logic [LENW-1:0] len);
        logic [BCW-1:0] w;
        w              = {BCW{1'b0}};
        w[LENW-1:0]    = len;
        w[BC_OVS]      = ovs;
        w[BC_ERR]      = err;
        return w;
    endfunction

endpackage

// File: rtl/gigerx_be_popcnt.sv
// Byte-enable to byte-count converter with a contiguity check
// (enables must run from bit 0 without gaps and be non-zero).
module gigerx_be_popcnt #(
    parameter int BEW = 8,
    parameter int CW  = $clog2(BEW + 1)
) (
    input  logic [BEW-1:0] be,
    output logic [CW-1:0]  cnt,
    output logic           contig
);

    logic [BEW-1:0] be_inc_s;

    // Population count of the enables.
    always_comb begin
        cnt = {CW{1'b0}};
        for (int i = 0; i < BEW; i++) begin
            cnt = cnt + CW'(be[i]);
        end
    end

    // A 0..01..1 pattern plus one is a power of two, so the AND is zero.
    assign be_inc_s = be + BEW'(1);
    assign contig   = (be != {BEW{1'b0}}) && ((be & be_inc_s) == {BEW{1'b0}});

endmodule

// File: rtl/gigerx_bcnt_gen.sv
// RX byte-count generator: accumulates per-frame byte counts and pushes one
// {err, oversize, len} word per frame into the byte-count FIFO.
module gigerx_bcnt_gen #(
    parameter int DW   = 64,
    parameter int LENW = gigerx_pkg::LENW,
    parameter int BCW  = gigerx_pkg::BCW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_val,
    input  logic            rx_sop,
    input  logic            rx_eop,
    input  logic [DW/8-1:0] rx_be,
    input  logic            rx_err,
    input  logic            bcnt_full,
    output logic            bcnt_wrreq,
    output logic [BCW-1:0]  bcnt_data,
    input  logic            clr_stats,
    output logic [31:0]     frame_cnt,
    output logic [15:0]     drop_cnt
);
    import gigerx_pkg::*;

    localparam int BEW = DW / 8;
    localparam int PCW = $clog2(BEW + 1);
    localparam logic [LENW-1:0] LEN_MAX = {LENW{1'b1}};

    logic [0:0]      state_r, state_n_s;
    logic [LENW-1:0] acc_r, acc_n_s;
    logic            ovs_r, ovs_n_s;
    logic            pend_vld_r, pend_vld_n_s;
    logic [BCW-1:0]  pend_word_r, pend_word_n_s;
    logic [31:0]     frame_cnt_r;
    logic [15:0]     drop_cnt_r, drop_n_s;
    logic [16:0]     drop_sum_s;
    logic [1:0]      drop_inc_s;

    logic [PCW-1:0]  pop_s;
    logic            contig_s;
    logic            eop_err_s;
    logic [LENW:0]   sum_beat_s, sum_eop_s;
    logic            c0_vld_s, c1_vld_s;
    logic [BCW-1:0]  c0_word_s, c1_word_s;
    logic            drain_s;

    function automatic logic [LENW-1:0] sat_len(input logic [LENW:0] s);
        if (s[LENW]) begin
            return LEN_MAX;
        end else begin
            return s[LENW-1:0];
        end
    endfunction

    gigerx_be_popcnt #(.BEW(BEW), .CW(PCW)) u_popcnt (
        .be     (rx_be),
        .cnt    (pop_s),
        .contig (contig_s)
    );

    assign eop_err_s  = rx_err | ~contig_s;
    assign sum_beat_s = {1'b0, acc_r} + (LENW+1)'(BEW);
    assign sum_eop_s  = {1'b0, acc_r} + (LENW+1)'(pop_s);
    assign drain_s    = pend_vld_r & ~bcnt_full;

    // Frame FSM: accumulate bytes and raise up to two commits per beat
    // (a missing-EOP abort plus a single-beat frame on the same SOP+EOP beat).
    always_comb begin
        state_n_s = state_r;
        acc_n_s   = acc_r;
        ovs_n_s   = ovs_r;
        c0_vld_s  = 1'b0;
        c0_word_s = {BCW{1'b0}};
        c1_vld_s  = 1'b0;
        c1_word_s = {BCW{1'b0}};
        if (rx_val) begin
            case (state_r)
                IDLE: begin
                    if (rx_sop && rx_eop) begin
                        c0_vld_s  = 1'b1;
                        c0_word_s = {eop_err_s, 1'b0, LENW'(pop_s)};
                    end else if (rx_sop) begin
                        state_n_s = IN_FRAME;
                        acc_n_s   = LENW'(BEW);
                        ovs_n_s   = 1'b0;
                    end else begin
                        state_n_s = IDLE;
                    end
                end
                IN_FRAME: begin
                    if (rx_sop) begin
                        c0_vld_s  = 1'b1;
                        c0_word_s = {1'b1, ovs_r, acc_r};
                        ovs_n_s   = 1'b0;
                        if (rx_eop) begin
                            c1_vld_s  = 1'b1;
                            c1_word_s = {eop_err_s, 1'b0, LENW'(pop_s)};
                            state_n_s = IDLE;
                            acc_n_s   = {LENW{1'b0}};
                        end else begin
                            acc_n_s   = LENW'(BEW);
                        end
                    end else if (rx_eop) begin
                        c0_vld_s  = 1'b1;
                        c0_word_s = {eop_err_s, ovs_r | sum_eop_s[LENW], sat_len(sum_eop_s)};
                        state_n_s = IDLE;
                        acc_n_s   = {LENW{1'b0}};
                        ovs_n_s   = 1'b0;
                    end else begin
                        acc_n_s   = sat_len(sum_beat_s);
                        ovs_n_s   = ovs_r | sum_beat_s[LENW];
                    end
                end
                default: begin
                    state_n_s = IDLE;
                    acc_n_s   = {LENW{1'b0}};
                    ovs_n_s   = 1'b0;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // Pending slot: a commit takes the slot if it is free or draining;
    // the second commit of a double-commit beat always finds it occupied.
    always_comb begin
        pend_vld_n_s  = pend_vld_r & ~drain_s;
        pend_word_n_s = pend_word_r;
        drop_inc_s    = 2'd0;
        if (c0_vld_s) begin
            if (!pend_vld_r || drain_s) begin
                pend_vld_n_s  = 1'b1;
                pend_word_n_s = c0_word_s;
            end else begin
                pend_vld_n_s  = 1'b1;
                drop_inc_s    = 2'd1;
            end
            if (c1_vld_s) begin
                drop_inc_s = drop_inc_s + 2'd1;
            end else begin
                drop_inc_s = drop_inc_s;
            end
        end else begin
            drop_inc_s = 2'd0;
        end
    end

    // Saturating drop counter next value.
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_r} + 17'(drop_inc_s);
        if (drop_sum_s[16]) begin
            drop_n_s = 16'hFFFF;
        end else begin
            drop_n_s = drop_sum_s[15:0];
        end
    end

    // Frame FSM and pending-slot state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= {LENW{1'b0}};
            ovs_r       <= 1'b0;
            pend_vld_r  <= 1'b0;
            pend_word_r <= {BCW{1'b0}};
        end else begin
            state_r     <= state_n_s;
            acc_r       <= acc_n_s;
            ovs_r       <= ovs_n_s;
            pend_vld_r  <= pend_vld_n_s;
            pend_word_r <= pend_word_n_s;
        end
    end

    // Statistics; a clear overrides any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 32'd0;
            drop_cnt_r  <= 16'd0;
        end else if (clr_stats) begin
            frame_cnt_r <= 32'd0;
            drop_cnt_r  <= 16'd0;
        end else begin
            frame_cnt_r <= frame_cnt_r + 32'(drain_s);
            drop_cnt_r  <= drop_n_s;
        end
    end

    assign bcnt_wrreq = drain_s;
    assign bcnt_data  = pend_word_r;
    assign frame_cnt  = frame_cnt_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_gigerx_bcnt_gen.sv
// Directed scoreboard bench for gigerx_bcnt_gen: expected FIFO words are
// queued with the stimulus and popped by a monitor on every write request.
module tb_gigerx_bcnt_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_val, rx_sop, rx_eop, rx_err;
    logic [7:0]  rx_be;
    logic        bcnt_full, clr_stats;
    logic        bcnt_wrreq;
    logic [15:0] bcnt_data;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;

    logic [15:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    gigerx_bcnt_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_val     (rx_val),
        .rx_sop     (rx_sop),
        .rx_eop     (rx_eop),
        .rx_be      (rx_be),
        .rx_err     (rx_err),
        .bcnt_full  (bcnt_full),
        .bcnt_wrreq (bcnt_wrreq),
        .bcnt_data  (bcnt_data),
        .clr_stats  (clr_stats),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every write request must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bcnt_wrreq) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got data %h, required no write", bcnt_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bcnt_data !== e) begin
                    n_bad++;
                    $display("FAIL write_data: got %h, required %h", bcnt_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [7:0] be, input logic err);
        rx_val = 1'b1; rx_sop = sop; rx_eop = eop; rx_be = be; rx_err = err;
        @(posedge clk); #1;
        rx_val = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_be = 8'h00; rx_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic mids(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'hFF, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rx_val = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_be = 8'h00;
        rx_err = 1'b0; bcnt_full = 1'b0; clr_stats = 1'b0;
        idle(3);
        chk("reset_wrreq", 32'(bcnt_wrreq), 32'd0);
        chk("reset_data", 32'(bcnt_data), 32'h0);
        chk("reset_frame_cnt", frame_cnt, 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 8-beat frame, 60 bytes, one-cycle latency
        exp_q.push_back(16'h003C);
        beat(1'b1, 1'b0, 8'hFF, 1'b0);
        mids(6);
        beat(1'b0, 1'b1, 8'h0F, 1'b0);
        chk("latency_wrreq", 32'(bcnt_wrreq), 32'd1);
        idle(3);
        chk("t1_frame_cnt", frame_cnt, 32'd1);

        // single-beat frame with MAC error
        exp_q.push_back(16'h8001);
        beat(1'b1, 1'b1, 8'h01, 1'b1);
        idle(3);
        chk("t2_frame_cnt", frame_cnt, 32'd2);

        // FIFO full across two 64-byte frames: first held, second dropped
        bcnt_full = 1'b1;
        exp_q.push_back(16'h0040);
        for (int f = 0; f < 2; f++) begin
            beat(1'b1, 1'b0, 8'hFF, 1'b0);
            mids(6);
            beat(1'b0, 1'b1, 8'hFF, 1'b0);
        end
        idle(2);
        chk("full_wrreq", 32'(bcnt_wrreq), 32'd0);
        chk("full_held_data", 32'(bcnt_data), 32'h0040);
        chk("full_drop_cnt", 32'(drop_cnt), 32'd1);
        bcnt_full = 1'b0;
        idle(3);
        chk("full_frame_cnt", frame_cnt, 32'd3);

        // clear coincides with a drain: clear wins
        exp_q.push_back(16'h0008);
        beat(1'b1, 1'b1, 8'hFF, 1'b0);
        clr_stats = 1'b1;
        idle(1);
        clr_stats = 1'b0;
        idle(2);
        chk("clr_frame_cnt", frame_cnt, 32'd0);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);

        // 2100-beat frame saturates the length
        exp_q.push_back(16'h7FFF);
        beat(1'b1, 1'b0, 8'hFF, 1'b0);
        mids(2098);
        beat(1'b0, 1'b1, 8'hFF, 1'b0);
        idle(3);
        chk("sat_frame_cnt", frame_cnt, 32'd1);

        // missing EOP after 3 beats, then non-contiguous BE on the new frame
        beat(1'b1, 1'b0, 8'hFF, 1'b0);
        mids(2);
        exp_q.push_back(16'h8018);
        beat(1'b1, 1'b0, 8'hFF, 1'b0);
        exp_q.push_back(16'h800A);
        beat(1'b0, 1'b1, 8'h05, 1'b0);
        idle(3);
        chk("abort_frame_cnt", frame_cnt, 32'd3);

        // reset on the 4th beat, then orphan beats produce nothing
        beat(1'b1, 1'b0, 8'hFF, 1'b0);
        mids(2);
        rx_val = 1'b1; rx_be = 8'hFF; rst_n = 1'b0;
        @(posedge clk); #1;
        rx_val = 1'b0; rx_be = 8'h00;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        beat(1'b0, 1'b0, 8'hFF, 1'b0);
        beat(1'b0, 1'b0, 8'hFF, 1'b0);
        beat(1'b0, 1'b1, 8'h0F, 1'b1);
        idle(2);
        chk("orphan_wrreq", 32'(bcnt_wrreq), 32'd0);
        chk("orphan_data", 32'(bcnt_data), 32'h0);
        chk("orphan_frame_cnt", frame_cnt, 32'd0);
        chk("orphan_drop_cnt", 32'(drop_cnt), 32'd0);
        exp_q.push_back(16'h0010);
        beat(1'b1, 1'b0, 8'hFF, 1'b0);
        beat(1'b0, 1'b1, 8'hFF, 1'b0);
        idle(3);
        chk("post_rst_frame_cnt", frame_cnt, 32'd1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
